// File: rtl/sha256_cfu_pkg.sv
// sha256_cfu_pkg: shared SHA-256 CFU constants, FSM states and sigma functions
package sha256_cfu_pkg;
  localparam int ID_W = 8;
  localparam int FN_W = 3;
  localparam int ST_W = 2;
  localparam logic [FN_W-1:0] FN_LOAD = 3'd0;
  localparam logic [FN_W-1:0] FN_EXPAND = 3'd1;
  localparam logic [FN_W-1:0] FN_CLEAR = 3'd2;
  localparam logic [ST_W-1:0] ST_OK = 2'd0;
  localparam logic [ST_W-1:0] ST_ILLEGAL = 2'd1;
  localparam logic [ST_W-1:0] ST_NOT_FULL = 2'd2;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction
endpackage

// File: rtl/sha256_msg_sched_if.sv
// cfu_interface: request/response channel between a CPU and a custom function unit
interface cfu_interface;
  import sha256_cfu_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [ID_W-1:0] req_id;
  logic [FN_W-1:0] req_function_id;
  logic [31:0] rs1;
  logic resp_valid;
  logic resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [ST_W-1:0] resp_status;
  logic [31:0] resp_data;
  modport master (output req_valid, req_id, req_function_id, rs1, resp_ready,
                  input req_ready, resp_valid, resp_id, resp_status, resp_data);
  modport slave (input req_valid, req_id, req_function_id, rs1, resp_ready,
                 output req_ready, resp_valid, resp_id, resp_status, resp_data);
endinterface

// File: rtl/sha256_msg_sched_window.sv
// sha256_sched_window: message-schedule shift window with fill count and expansion taps
module sha256_sched_window #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] w0,
  output logic [31:0] w1,
  output logic [31:0] w9,
  output logic [31:0] w14,
  output logic        full
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][31:0] w;
  logic [CW-1:0] cnt;
  assign w0 = w[0];
  assign w1 = w[1];
  assign w9 = w[DEPTH-7];
  assign w14 = w[DEPTH-2];
  assign full = cnt == CW'(DEPTH);
  // newest word enters at the top, oldest falls off index 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '0;
      cnt <= '0;
    end else if (clear) begin
      w <= '0;
      cnt <= '0;
    end else if (load) begin
      w <= {din, w[DEPTH-1:1]};
      cnt <= full ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: CFU computing the SHA-256 message schedule W16..W63 over a 16-word window
module sha256_msg_sched
  import sha256_cfu_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic rst,
  cfu_interface.slave cfu
);
  state_t state, next;
  logic [31:0] s0, s1, wn, w0, w1, w9, w14, din;
  logic full, accept, legal_exp, load, clear;
  logic [FN_W-1:0] fn;
  assign fn = cfu.req_function_id;
  assign accept = state == IDLE && cfu.req_valid;
  assign legal_exp = fn == FN_EXPAND && full;
  assign wn = s0 + s1;
  assign cfu.req_ready = state == IDLE;
  assign cfu.resp_valid = state == RESP;
  sha256_sched_window #(.DEPTH(WINDOW)) u_win (
    .clk(clk), .rst(rst), .load(load), .clear(clear), .din(din),
    .w0(w0), .w1(w1), .w9(w9), .w14(w14), .full(full)
  );
  always_comb begin
    next = state == IDLE ? (accept ? (legal_exp ? EXEC : RESP) : IDLE)
         : state == EXEC ? RESP
         : (cfu.resp_ready ? IDLE : RESP);
    load = (accept && fn == FN_LOAD) || state == EXEC;
    clear = accept && fn == FN_CLEAR;
    din = state == EXEC ? wn : cfu.rs1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  // expansion splits into two partial sums so each cycle has a single 32-bit add chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
      cfu.resp_id <= '0;
      cfu.resp_status <= ST_OK;
      cfu.resp_data <= '0;
    end else if (accept) begin
      cfu.resp_id <= cfu.req_id;
      cfu.resp_status <= (fn == FN_LOAD || fn == FN_CLEAR) ? ST_OK
                       : fn == FN_EXPAND ? (full ? ST_OK : ST_NOT_FULL) : ST_ILLEGAL;
      cfu.resp_data <= fn == FN_LOAD ? cfu.rs1 : '0;
      if (legal_exp) begin
        s0 <= sig0(w1) + w0;
        s1 <= sig1(w14) + w9;
      end
    end else if (state == EXEC) begin
      cfu.resp_data <= wn;
    end
  end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: scoreboard bench for the SHA-256 message-schedule CFU
module tb_sha256_msg_sched;
  typedef struct {
    logic [7:0] id;
    logic [1:0] st;
    logic [31:0] data;
    int lat;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int n_asrt = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [31:0] mw[16];
  int mcnt = 0;
  logic [7:0] nid = 0;
  logic [31:0] got;
  cfu_interface cfu();
  sha256_msg_sched dut (.clk(clk), .rst(rst), .cfu(cfu));
  always #5 clk = ~clk;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ms0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ms1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mshift(input logic [31:0] d);
    for (int i = 0; i < 15; i++) mw[i] = mw[i + 1];
    mw[15] = d;
    if (mcnt < 16) mcnt++;
  endtask
  task automatic mclear();
    for (int i = 0; i < 16; i++) mw[i] = 0;
    mcnt = 0;
  endtask
  task automatic xact(input logic [2:0] fn, input logic [7:0] id, input logic [31:0] d,
                      input bit stall, output logic [31:0] data);
    exp_t e;
    logic [31:0] wn, hd, hi;
    int lat, n;
    e.id = id; e.st = 0; e.data = 0; e.lat = 1;
    if (fn == 0) begin
      e.data = d; mshift(d);
    end else if (fn == 1) begin
      if (mcnt < 16) e.st = 2;
      else begin
        wn = ms1(mw[14]) + mw[9] + ms0(mw[1]) + mw[0];
        e.data = wn; e.lat = 2; mshift(wn);
      end
    end else if (fn == 2) mclear();
    else e.st = 1;
    sb.push_back(e);
    @(negedge clk);
    n = 0;
    while (!cfu.req_ready && n < 20) begin @(negedge clk); n++; end
    cfu.req_valid = 1; cfu.req_function_id = fn; cfu.req_id = id; cfu.rs1 = d;
    cfu.resp_ready = !stall;
    @(posedge clk); #1;
    cfu.req_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!cfu.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    if (!cfu.resp_valid) begin
      check("resp_timeout", 0, 1);
      cfu.resp_ready = 1;
      data = 'x;
      return;
    end
    if (stall) begin
      hd = cfu.resp_data; hi = 32'(cfu.resp_id);
      for (int i = 0; i < 10; i++) begin
        check("stall_valid", 32'(cfu.resp_valid), 1);
        check("stall_data", cfu.resp_data, hd);
        check("stall_id", 32'(cfu.resp_id), hi);
        check("stall_rdy", 32'(cfu.req_ready), 0);
        cfu.req_valid = (i % 2) == 0;
        cfu.req_function_id = 3'd2;
        cfu.req_id = 8'hEE;
        @(negedge clk);
      end
      cfu.req_valid = 0;
      cfu.resp_ready = 1;
    end
    check("resp_id", 32'(cfu.resp_id), 32'(e.id));
    check("resp_status", 32'(cfu.resp_status), 32'(e.st));
    check("resp_data", cfu.resp_data, e.data);
    check("latency", 32'(lat), 32'(e.lat));
    data = cfu.resp_data;
    @(posedge clk); #1;
  endtask
  task automatic op(input logic [2:0] fn, input logic [31:0] d);
    nid++;
    xact(fn, nid, d, 0, got);
  endtask
  initial begin
    cfu.req_valid = 0; cfu.req_id = 0; cfu.req_function_id = 0; cfu.rs1 = 0; cfu.resp_ready = 1;
    mclear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(cfu.req_ready), 1);
    check("rst_resp_valid", 32'(cfu.resp_valid), 0);
    check("rst_resp_data", cfu.resp_data, 0);
    check("rst_resp_id", 32'(cfu.resp_id), 0);
    check("rst_resp_status", 32'(cfu.resp_status), 0);
    check("rst_cnt", 32'(dut.u_win.cnt), 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 16; i++) op(0, i == 0 ? 32'h61626380 : i == 15 ? 32'h18 : 32'h0);
    op(1, 0);
    check("abc_w16", got, 32'h61626380);
    op(1, 0);
    check("abc_w17", got, 32'h000F0000);
    for (int i = 18; i < 64; i++) op(1, 0);
    op(2, 0);
    for (int i = 0; i < 15; i++) op(0, 32'h1000 + 32'(i));
    op(1, 0);
    check("notfull_data", got, 0);
    op(0, 32'hDEADBEEF);
    op(1, 0);
    xact(3'd5, 8'd3, 32'h12345678, 0, got);
    op(1, 0);
    xact(3'd0, 8'h5A, 32'hCAFEF00D, 1, got);
    op(1, 0);
    @(negedge clk);
    cfu.req_valid = 1; cfu.req_function_id = 1; cfu.req_id = 8'h77;
    @(posedge clk); #1;
    cfu.req_valid = 0;
    rst = 1; #1;
    check("rstx_resp_valid", 32'(cfu.resp_valid), 0);
    check("rstx_req_ready", 32'(cfu.req_ready), 1);
    check("rstx_cnt", 32'(dut.u_win.cnt), 0);
    mclear();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstx_stray", 32'(cfu.resp_valid), 0);
    end
    op(1, 0);
    for (int i = 0; i < 16; i++) op(0, $urandom);
    op(1, 0);
    op(1, 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 Port rst, input, 1, asynchronous active-high reset.
REQ-003 Port cfu, cfu_interface.slave; fields used: req_valid, req_ready, req_id, req_function_id, rs1, resp_valid, resp_ready, resp_id, resp_status, resp_data (32).
REQ-004 Parameter WINDOW, default 16, depth of message-schedule window (fixed by SHA-256; other values unsupported).

Function
REQ-005 Block SHALL hold a 16x32 window W[0..15], W[0] oldest, plus a fill counter CNT of 0..16.
REQ-006 req_function_id decode SHALL be:
- 0 LOAD: shift rs1 into W[15], W[i] <= W[i+1]; CNT saturates at 16; resp_data = rs1.
- 1 EXPAND: Wn = sig1(W[14]) + W[9] + sig0(W[1]) + W[0], mod 2^32; shift Wn in as LOAD; resp_data = Wn.
- 2 CLEAR: W and CNT to 0; resp_data = 0.
- other: no state change; resp_data = 0; resp_status = ST_ILLEGAL.
REQ-007 sig0(x) = ROR(x,7) ^ ROR(x,18) ^ SHR(x,3); sig1(x) = ROR(x,17) ^ ROR(x,19) ^ SHR(x,10).
REQ-008 EXPAND with CNT < 16 SHALL not modify W or CNT and SHALL respond with resp_data 0, resp_status ST_NOT_FULL.
REQ-009 Successful operations SHALL respond with resp_status ST_OK (0).
REQ-010 FSM states IDLE, EXEC, RESP. IDLE: req_ready = 1. Accept (req_valid & req_ready) -> EXEC for a legal EXEC-class EXPAND, else -> RESP. EXEC -> RESP unconditionally. RESP -> IDLE when resp_ready.
REQ-011 EXPAND SHALL be two-stage: on accept register s0 = sig0(W[1]) + W[0] and s1 = sig1(W[14]) + W[9]; in EXEC compute Wn = s0 + s1, shift window, load resp_data.
REQ-012 Latency accept-to-resp_valid: 1 cycle for LOAD/CLEAR/illegal/not-full, 2 cycles for EXPAND.
REQ-013 resp_id SHALL equal the accepted req_id; resp_id/resp_data/resp_status captured when the response is formed and held stable while resp_valid = 1 and resp_ready = 0.
REQ-014 resp_valid = 1 only in RESP; req_ready = 1 only in IDLE; one request outstanding at most.
REQ-015 No request is accepted in the cycle RESP is left; next accept is earliest the following cycle in IDLE.
REQ-016 LOAD at CNT = 16 SHALL discard W[0] and keep CNT at 16; window shift is a wrap-free FIFO discard.
REQ-017 req_valid while not in IDLE SHALL be ignored (no state change).

Reset
REQ-018 rst SHALL asynchronously force: FSM IDLE, req_ready 1, resp_valid 0, resp_id 0, resp_status 0, resp_data 0, CNT 0, W all 0, s0/s1 0.
REQ-019 rst asserted mid-EXPAND (EXEC) or mid-RESP SHALL abandon the operation; no response is later emitted, window not shifted.

Structure
REQ-020 Shared package sha256_cfu_pkg SHALL hold function-code constants (FN_LOAD, FN_EXPAND, FN_CLEAR), status codes (ST_OK=0, ST_ILLEGAL=1, ST_NOT_FULL=2), FSM state enum, and sig0/sig1 functions (shared with existing sigma CFUs).
REQ-021 One sub-module sha256_sched_window (16x32 shift register with CNT, load/clear inputs, W[0]/W[1]/W[9]/W[14] taps) SHALL be instantiated; FSM and adders stay in top.

Verification
REQ-022 Load "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), EXPAND -> resp_data 0x61626380, status 0, 2-cycle latency.
REQ-023 Continue with second EXPAND -> resp_data 0x000F0000; run through W63 and match software golden model for all 48 words.
REQ-024 After CLEAR plus 15 LOADs, EXPAND -> status 2, data 0; one more LOAD then EXPAND -> status 0.
REQ-025 Function id 5 with req_id 3 -> resp_id 3, status 1, data 0, window unchanged (checked by subsequent EXPAND result).
REQ-026 Hold resp_ready 0 for 10 cycles during response -> resp_valid, resp_data, resp_id stable, req_ready 0; req_valid pulses ignored.
REQ-027 Assert rst in EXEC cycle -> resp_valid 0 immediately, req_ready 1, CNT 0; no stray response after release.
